// File: rtl/intr_ctrl_multi.sv
// Multi-channel interrupt/enable handshake controller: arbitrates NCH request
// lines and services one channel at a time, aborting stuck services on timeout.
module intr_ctrl_multi #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4,
  parameter bit RR_EN   = 1'b1,
  localparam int IW     = $clog2(NCH)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [NCH-1:0] eql,
  input  logic           cont_eql,
  output logic [1:0]     cc_mux,
  output logic [1:0]     uscite,
  output logic           enable_count,
  output logic           ackout,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  chan_id,
  output logic           timeout_err
);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] INTR_1 = 3'd2;
  localparam logic [2:0] ENIN   = 3'd3;
  localparam logic [2:0] ENIN_W = 3'd4;
  localparam logic [2:0] INTR   = 3'd5;
  localparam logic [2:0] INTR_W = 3'd6;

  logic [2:0]       st, st_n;
  logic [IW-1:0]    cur, cur_n, last, last_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       cc_n, us_n;
  logic             en_n, terr_n, any, req, tmo, svc_n;
  logic [NCH-1:0]   grant_n;
  int               k;

  assign any = |eql;
  assign req = eql[cur];
  assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

  // Walk the search order backwards so the earliest hit is the last assignment.
  always_comb begin
    pick = '0;
    k    = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = RR_EN ? (int'(last) + 1 + i) % NCH : i;
      if (eql[IW'(k)]) pick = IW'(k);
    end
  end

  always_comb begin
    st_n   = st;
    cur_n  = cur;
    last_n = last;
    cnt_n  = '0;
    cc_n   = cc_mux;
    us_n   = uscite;
    en_n   = ~cont_eql;
    terr_n = 1'b0;
    case (st)
      INIT: begin
        st_n = WAIT; us_n = 2'b01; cc_n = 2'b01;
      end
      WAIT, INTR_1: begin
        if (any) begin
          cur_n = pick; us_n = 2'b00; cc_n = 2'b11;
          st_n  = (st == WAIT) ? ENIN : INTR;
        end else begin
          us_n = 2'b01;
          cc_n = (st == WAIT) ? 2'b10 : 2'b01;
          st_n = (st == WAIT) ? INTR_1 : WAIT;
        end
      end
      ENIN, ENIN_W, INTR, INTR_W: begin
        if (req && tmo) begin
          st_n = WAIT; us_n = 2'b01; cc_n = 2'b01; last_n = cur; terr_n = 1'b1;
        end else if (req) begin
          cnt_n = cnt + 1'b1;
          case (st)
            ENIN, INTR: begin us_n = 2'b00; cc_n = 2'b11; end
            ENIN_W:     begin us_n = 2'b01; cc_n = 2'b01; end
            default:    begin us_n = 2'b11; cc_n = 2'b10; end
          endcase
        end else begin
          case (st)
            ENIN: begin
              st_n = ENIN_W; us_n = 2'b01; cc_n = 2'b01; en_n = 1'b1;
            end
            INTR: begin
              st_n = INTR_W; us_n = 2'b11; cc_n = 2'b10;
            end
            default: begin
              st_n = WAIT; us_n = 2'b01; cc_n = 2'b01; last_n = cur;
            end
          endcase
        end
      end
      default: st_n = INIT;
    endcase
  end

  assign svc_n = (st_n == ENIN) || (st_n == ENIN_W) || (st_n == INTR) || (st_n == INTR_W);

  for (genvar i = 0; i < NCH; i++) begin : g_grant
    assign grant_n[i] = svc_n && (cur_n == IW'(i));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st           <= INIT;
      cur          <= '0;
      last         <= IW'(NCH - 1);
      cnt          <= '0;
      cc_mux       <= '0;
      uscite       <= '0;
      enable_count <= 1'b0;
      ackout       <= 1'b0;
      grant        <= '0;
      chan_id      <= '0;
      timeout_err  <= 1'b0;
    end else begin
      st           <= st_n;
      cur          <= cur_n;
      last         <= last_n;
      cnt          <= cnt_n;
      cc_mux       <= cc_n;
      uscite       <= us_n;
      enable_count <= en_n;
      ackout       <= en_n;
      grant        <= grant_n;
      if (svc_n) chan_id <= cur_n;
      timeout_err  <= terr_n;
    end
  end

endmodule

// File: tb/tb_intr_ctrl_multi.sv
// Bench for intr_ctrl_multi: a round-robin and a fixed-priority instance driven
// from a vector table through an expectation queue, plus a mid-service reset.
module tb_intr_ctrl_multi;

  typedef struct {
    logic       sel;
    logic [3:0] e;
    logic       ce;
    logic [1:0] cc;
    logic [1:0] us;
    logic       en;
    logic [3:0] g;
    logic [1:0] ch;
    logic       t;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] eql = '0;
  logic       cont_eql = 1'b0;

  logic [1:0] cc1, us1, cc0, us0;
  logic       en1, ack1, te1, en0, ack0, te0;
  logic [3:0] g1, g0;
  logic [1:0] ch1, ch0;

  vec_t tab[$];
  vec_t exp_q[$];
  vec_t mv;
  int   vn = 0;
  int   na = 0;
  int   total = 0;
  int   bad = 0;
  logic pt1 = 1'b0, pt0 = 1'b0;
  logic [1:0] a_cc, a_us, a_ch;
  logic       a_en, a_ack, a_t;
  logic [3:0] a_g;

  intr_ctrl_multi #(.NCH(4), .TIMEOUT(8), .CNT_W(4), .RR_EN(1'b1)) dut_rr (
    .clock(clock), .reset_n(reset_n), .eql(eql), .cont_eql(cont_eql),
    .cc_mux(cc1), .uscite(us1), .enable_count(en1), .ackout(ack1),
    .grant(g1), .chan_id(ch1), .timeout_err(te1)
  );

  intr_ctrl_multi #(.NCH(4), .TIMEOUT(8), .CNT_W(4), .RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset_n(reset_n), .eql(eql), .cont_eql(cont_eql),
    .cc_mux(cc0), .uscite(us0), .enable_count(en0), .ackout(ack0),
    .grant(g0), .chan_id(ch0), .timeout_err(te0)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(int sel, int e, int ce, int cc, int us, int en, int g, int ch, int t);
    vec_t v;
    v.sel = 1'(sel); v.e = 4'(e); v.ce = 1'(ce); v.cc = 2'(cc); v.us = 2'(us);
    v.en = 1'(en); v.g = 4'(g); v.ch = 2'(ch); v.t = 1'(t);
    tab.push_back(v);
  endfunction

  task automatic chk_zero(input string name, input logic sel);
    if (sel) begin
      chk({name, "_cc"}, 0, 16'(cc1), 16'h0);  chk({name, "_us"}, 0, 16'(us1), 16'h0);
      chk({name, "_en"}, 0, 16'(en1), 16'h0);  chk({name, "_ack"}, 0, 16'(ack1), 16'h0);
      chk({name, "_g"}, 0, 16'(g1), 16'h0);    chk({name, "_ch"}, 0, 16'(ch1), 16'h0);
      chk({name, "_t"}, 0, 16'(te1), 16'h0);
    end else begin
      chk({name, "_cc"}, 0, 16'(cc0), 16'h0);  chk({name, "_us"}, 0, 16'(us0), 16'h0);
      chk({name, "_en"}, 0, 16'(en0), 16'h0);  chk({name, "_ack"}, 0, 16'(ack0), 16'h0);
      chk({name, "_g"}, 0, 16'(g0), 16'h0);    chk({name, "_ch"}, 0, 16'(ch0), 16'h0);
      chk({name, "_t"}, 0, 16'(te0), 16'h0);
    end
  endtask

  // Scoreboard side: each edge retires the oldest expectation and checks invariants.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mv = exp_q.pop_front();
      if (mv.sel) begin
        a_cc = cc1; a_us = us1; a_en = en1; a_ack = ack1; a_g = g1; a_ch = ch1; a_t = te1;
      end else begin
        a_cc = cc0; a_us = us0; a_en = en0; a_ack = ack0; a_g = g0; a_ch = ch0; a_t = te0;
      end
      chk("cc_mux", vn, 16'(a_cc), 16'(mv.cc));
      chk("uscite", vn, 16'(a_us), 16'(mv.us));
      chk("enable_count", vn, 16'(a_en), 16'(mv.en));
      chk("ackout", vn, 16'(a_ack), 16'(mv.en));
      chk("grant", vn, 16'(a_g), 16'(mv.g));
      chk("chan_id", vn, 16'(a_ch), 16'(mv.ch));
      chk("timeout_err", vn, 16'(a_t), 16'(mv.t));
      vn++;
    end
    chk("inv_ack_rr", vn, 16'(ack1), 16'(en1));
    chk("inv_ack_fp", vn, 16'(ack0), 16'(en0));
    chk("inv_us_rr", vn, 16'(us1 == 2'b10), 16'h0);
    chk("inv_us_fp", vn, 16'(us0 == 2'b10), 16'h0);
    chk("inv_grant_rr", vn, 16'($onehot0(g1)), 16'h1);
    chk("inv_grant_fp", vn, 16'($onehot0(g0)), 16'h1);
    chk("inv_terr_rr", vn, 16'(te1 && pt1), 16'h0);
    chk("inv_terr_fp", vn, 16'(te0 && pt0), 16'h0);
    pt1 = te1;
    pt0 = te0;
  end

  initial begin
    // sel, eql, cont_eql, cc_mux, uscite, en/ack, grant, chan_id, timeout_err
    add(1, 0, 0, 'b01, 'b01, 1, 0, 0, 0);
    add(1, 0, 0, 'b10, 'b01, 1, 0, 0, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 0, 0, 0);
    add(1, 0, 1, 'b10, 'b01, 0, 0, 0, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      int ch, ce, g;
      ch = c % 4; ce = (c == 2) ? 1 : 0; g = 1 << ch;
      add(1, 'b1111, ce, 'b11, 'b00, 1 - ce, g, ch, 0);
      add(1, 'b0000, ce, 'b01, 'b01, 1, g, ch, 0);
      add(1, 'b0000, ce, 'b01, 'b01, 1 - ce, 0, ch, 0);
    end
    for (int i = 0; i < 8; i++) add(1, 'b0110, 0, 'b11, 'b00, 1, 'b0010, 1, 0);
    add(1, 'b0110, 0, 'b01, 'b01, 1, 0, 1, 1);
    add(1, 'b0110, 0, 'b11, 'b00, 1, 'b0100, 2, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 'b0100, 2, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 0, 2, 0);
    // Request drops on the very edge the counter hits its limit: no abort.
    for (int i = 0; i < 8; i++) add(1, 'b1000, 0, 'b11, 'b00, 1, 'b1000, 3, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 'b1000, 3, 0);
    add(1, 0, 0, 'b01, 'b01, 1, 0, 3, 0);
    add(1, 0, 1, 'b10, 'b01, 0, 0, 3, 0);
    add(1, 'b0100, 1, 'b11, 'b00, 0, 'b0100, 2, 0);
    add(1, 0, 1, 'b10, 'b11, 0, 'b0100, 2, 0);
    add(1, 'b0100, 1, 'b10, 'b11, 0, 'b0100, 2, 0);
    add(1, 0, 1, 'b01, 'b01, 0, 0, 2, 0);
    add(1, 0, 0, 'b10, 'b01, 1, 0, 2, 0);
    add(1, 'b0001, 0, 'b11, 'b00, 1, 'b0001, 0, 0);
    add(1, 0, 0, 'b10, 'b11, 1, 'b0001, 0, 0);
    add(1, 'b0001, 0, 'b10, 'b11, 1, 'b0001, 0, 0);
    na = tab.size();
    add(0, 0, 0, 'b01, 'b01, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      add(0, 'b1010, 0, 'b11, 'b00, 1, 'b0010, 1, 0);
      add(0, 0, 0, 'b01, 'b01, 1, 'b0010, 1, 0);
      add(0, 0, 0, 'b01, 'b01, 1, 0, 1, 0);
    end

    repeat (2) @(negedge clock);
    chk_zero("reset_rr", 1'b1);
    chk_zero("reset_fp", 1'b0);

    for (int i = 0; i < na; i++) begin
      @(negedge clock);
      if (i == 0) reset_n = 1'b1;
      eql = tab[i].e; cont_eql = tab[i].ce;
      exp_q.push_back(tab[i]);
    end
    @(negedge clock);
    // Sitting in INTR_W with the request still held; reset lands between edges.
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst", 1'b1);
    @(posedge clock);
    #1 chk_zero("held_rst", 1'b1);

    for (int i = na; i < tab.size(); i++) begin
      @(negedge clock);
      if (i == na) reset_n = 1'b1;
      eql = tab[i].e; cont_eql = tab[i].ce;
      exp_q.push_back(tab[i]);
    end
    repeat (2) @(negedge clock);
    chk("queue_drained", 0, 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
